serial_bus_slave: RTL and testbench
===================================

SERIAL_BUS_SLAVE -- requirements
Module: serial_bus_slave

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning local memory address width (depth 2**ADDR_W bytes).
REQ-002 SHALL have parameter DEV_ID, default 8'hA5, width 16-ADDR_W, meaning the value of ADDR[15:ADDR_W] that selects this slave.
REQ-003 SHALL have port CLK  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port RSTN  input  1  reset; synchronous, active-high (asserted when 1, sampled only at a CLK rising edge).
REQ-005 SHALL have port B_UTIL  input  1  master holds high for the entire transaction; low = bus idle or transaction abort.
REQ-006 SHALL have port B_RW  input  1  1 = write, 0 = read.
REQ-007 SHALL have port B_BUS  inout  1  serial address/data line, MSB first.
REQ-008 SHALL have port B_ACK  output  1  slave acknowledge.
REQ-009 SHALL have port S_BSY  output  1  high whenever FSM is not IDLE.
REQ-010 SHALL have port S_WR_DONE  output  1  one-cycle pulse when a write byte is committed to memory.
REQ-011 SHALL have port S_WP  input  1  write protect; present only when SLAVE_WRITE_PROTECT_EN is defined.

Function
REQ-012 SHALL implement FSM states IDLE, ADDRESS, ACKA, WDATA, ACKW, RDATA, WAIT_END, and a bit counter.
REQ-013 IDLE: a cycle with B_UTIL=1 SHALL sample B_BUS as address bit 15 and move to ADDRESS with count=1.
REQ-014 ADDRESS: each cycle SHALL shift B_BUS into the address register; on the 16th sampled bit SHALL latch B_RW and evaluate match = (ADDR[15:ADDR_W]==DEV_ID).
REQ-015 After the 16th bit: match SHALL enter ACKA; no match SHALL enter WAIT_END with B_ACK kept 0.
REQ-016 ACKA SHALL last exactly 4 cycles with registered B_ACK=1 in all 4 (set on the edge entering ACKA), then go to WDATA if latched B_RW=1, else RDATA.
REQ-017 WDATA: 8 cycles SHALL shift B_BUS into a data register MSB first; the edge that samples bit 0 SHALL enter ACKW.
REQ-018 On entering ACKW the byte SHALL be written to mem[ADDR[ADDR_W-1:0]] and S_WR_DONE pulsed for exactly that first ACKW cycle.
REQ-019 ACKW SHALL last 4 cycles with B_ACK=1 in all 4, then enter WAIT_END.
REQ-020 RDATA: on entry, mem[ADDR[ADDR_W-1:0]] SHALL be loaded into a shift register; slave SHALL drive B_BUS with bit 7 in the first RDATA cycle through bit 0 in the 8th, then enter WAIT_END.
REQ-021 B_BUS SHALL be driven only during RDATA and SHALL be high-impedance in every other state and during reset.
REQ-022 WAIT_END SHALL hold until B_UTIL=0, then return to IDLE; B_UTIL=1 in WAIT_END SHALL NOT start a new transaction.
REQ-023 B_UTIL=0 in ADDRESS, ACKA, WDATA, ACKW or RDATA SHALL abort to IDLE on the next edge: B_ACK=0, counter cleared, B_BUS released, no memory write if abort occurs before ACKW entry.
REQ-024 A write committed on ACKW entry SHALL remain committed if B_UTIL drops during ACKW.
REQ-025 Memory content SHALL change only through REQ-018.
REQ-026 The bit counter SHALL clear on every state change; a count SHALL never wrap within a state.

Reset
REQ-027 RSTN=1 at a rising edge SHALL force state=IDLE, counter=0, B_ACK=0, S_WR_DONE=0, B_BUS=Z, and address/data shift registers=0, taking priority over any transaction in progress.
REQ-028 Reset SHALL clear all memory bytes to 8'h00.
REQ-029 S_BSY SHALL be 0 in the first cycle after reset.

Configuration
REQ-030 Macro SLAVE_WRITE_PROTECT_EN defined: port S_WP SHALL exist; S_WP=1 sampled on the edge entering ACKW SHALL suppress the memory write, S_WR_DONE and B_ACK (B_ACK=0 for all 4 ACKW cycles, a NAK); all other timing SHALL be unchanged.
REQ-031 Macro SLAVE_WRITE_PROTECT_EN undefined: S_WP SHALL be absent and every write reaching ACKW SHALL be committed and acknowledged.

Verification
REQ-032 Write 16'hA534 data 8'h5C -> B_ACK high 4 cycles after bit 16, S_WR_DONE pulse, B_ACK high 4 cycles, mem[8'h34]=8'h5C.
REQ-033 Then read 16'hA534 -> B_ACK 4 cycles, B_BUS = 0,1,0,1,1,1,0,0 over the next 8 cycles, then Z.
REQ-034 Write 16'h1234 data 8'hFF -> B_ACK stays 0, B_BUS stays Z, no memory changes, slave returns to IDLE once B_UTIL=0.
REQ-035 Write 16'hA510 with B_UTIL dropped after data bit 4 -> IDLE on next edge, mem[8'h10] unchanged, next transaction decodes normally.
REQ-036 RSTN=1 during RDATA bit 3 -> B_BUS=Z and B_ACK=0 next cycle, S_BSY=0, all memory reads 8'h00.
REQ-037 With SLAVE_WRITE_PROTECT_EN and S_WP=1: write 16'hA501 data 8'h77 -> address ACK present, ACKW B_ACK=0, no S_WR_DONE, mem[8'h01] unchanged.

Source files
------------

// File: rtl/serial_bus_slave.sv
// rtl/serial_bus_slave.sv - serial address/data bus slave with local byte memory
// Optional write-protect input S_WP is built in when SLAVE_WRITE_PROTECT_EN is defined.
module serial_bus_slave #(
    parameter int ADDR_W = 8,
    parameter logic [15-ADDR_W:0] DEV_ID = 8'hA5
) (
    input  logic CLK,
    input  logic RSTN,
    input  logic B_UTIL,
    input  logic B_RW,
    inout  wire  B_BUS,
    output logic B_ACK,
    output logic S_BSY,
    output logic S_WR_DONE
`ifdef SLAVE_WRITE_PROTECT_EN
    ,
    input  logic S_WP
`endif
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDRESS  = 3'd1,
        ACKA     = 3'd2,
        WDATA    = 3'd3,
        ACKW     = 3'd4,
        RDATA    = 3'd5,
        WAIT_END = 3'd6
    } state_t;

    localparam int DEPTH = 1 << ADDR_W;

    state_t            state, state_nxt;
    logic [3:0]        cnt;
    logic [15:0]       addr_sh, addr_nxt;
    logic [7:0]        data_sh, wr_byte, rd_sh;
    logic              rw_q, match, wr_en, wp_in, bus_oe;
    logic [ADDR_W-1:0] mem_idx;
    logic [7:0]        mem [DEPTH];

`ifdef SLAVE_WRITE_PROTECT_EN
    assign wp_in = S_WP;
`else
    assign wp_in = 1'b0;
`endif

    assign mem_idx  = addr_sh[ADDR_W-1:0];
    assign addr_nxt = (state == IDLE) ? {15'd0, B_BUS} : {addr_sh[14:0], B_BUS};
    assign match    = (addr_nxt[15:ADDR_W] == DEV_ID);
    assign wr_byte  = {data_sh[6:0], B_BUS};
    assign wr_en    = (state == WDATA) && B_UTIL && (cnt == 4'd7) && !wp_in;
    // Release the line combinationally while reset is asserted, not just after the edge.
    assign bus_oe   = (state == RDATA) && !RSTN;
    assign B_BUS    = bus_oe ? rd_sh[7] : 1'bz;
    assign S_BSY    = (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (B_UTIL) state_nxt = ADDRESS;
            end
            ADDRESS: begin
                if (!B_UTIL)           state_nxt = IDLE;
                else if (cnt == 4'd15) state_nxt = match ? ACKA : WAIT_END;
            end
            ACKA: begin
                if (!B_UTIL)          state_nxt = IDLE;
                else if (cnt == 4'd3) state_nxt = rw_q ? WDATA : RDATA;
            end
            WDATA: begin
                if (!B_UTIL)          state_nxt = IDLE;
                else if (cnt == 4'd7) state_nxt = ACKW;
            end
            ACKW: begin
                if (!B_UTIL)          state_nxt = IDLE;
                else if (cnt == 4'd3) state_nxt = WAIT_END;
            end
            RDATA: begin
                if (!B_UTIL)          state_nxt = IDLE;
                else if (cnt == 4'd7) state_nxt = WAIT_END;
            end
            WAIT_END: begin
                if (!B_UTIL) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RSTN) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            addr_sh   <= 16'd0;
            data_sh   <= 8'd0;
            rd_sh     <= 8'd0;
            rw_q      <= 1'b0;
            B_ACK     <= 1'b0;
            S_WR_DONE <= 1'b0;
        end else begin
            state     <= state_nxt;
            S_WR_DONE <= wr_en;

            // IDLE has already consumed address bit 15, so ADDRESS starts counting at 1.
            if (state_nxt != state)
                cnt <= (state_nxt == ADDRESS) ? 4'd1 : 4'd0;
            else if (state != IDLE && state != WAIT_END)
                cnt <= cnt + 4'd1;

            if ((state == IDLE || state == ADDRESS) && B_UTIL)
                addr_sh <= addr_nxt;
            if (state == ADDRESS && B_UTIL && cnt == 4'd15)
                rw_q <= B_RW;
            if (state == WDATA && B_UTIL)
                data_sh <= wr_byte;

            if (state == ACKA && state_nxt == RDATA)
                rd_sh <= mem[mem_idx];
            else if (state == RDATA)
                rd_sh <= {rd_sh[6:0], 1'b0};

            // Write-protect decides the ACKW acknowledge once, on entry, and it is held.
            case (state_nxt)
                ACKA:    B_ACK <= 1'b1;
                ACKW:    B_ACK <= (state == ACKW) ? B_ACK : !wp_in;
                default: B_ACK <= 1'b0;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RSTN) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
        end else if (wr_en) begin
            mem[mem_idx] <= wr_byte;
        end
    end

endmodule

// File: tb/tb_serial_bus_slave.sv
// tb/tb_serial_bus_slave.sv - randomized self-checking bench for serial_bus_slave
// Honours SLAVE_WRITE_PROTECT_EN the same way as the design.
module tb_serial_bus_slave;

    logic CLK = 1'b0;
    logic RSTN;
    logic B_UTIL;
    logic B_RW;
    wire  B_BUS;
    logic B_ACK;
    logic S_BSY;
    logic S_WR_DONE;
`ifdef SLAVE_WRITE_PROTECT_EN
    logic S_WP;
`endif

    logic drv_en;
    logic drv_val;
    int   n_chk = 0;
    int   n_bad = 0;
    logic [7:0] mem_m [256];

    pullup (B_BUS);
    assign B_BUS = drv_en ? drv_val : 1'bz;

    always #5 CLK = ~CLK;

    serial_bus_slave dut (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .B_UTIL    (B_UTIL),
        .B_RW      (B_RW),
        .B_BUS     (B_BUS),
        .B_ACK     (B_ACK),
        .S_BSY     (S_BSY),
        .S_WR_DONE (S_WR_DONE)
`ifdef SLAVE_WRITE_PROTECT_EN
        ,
        .S_WP      (S_WP)
`endif
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Master releases the line right after each edge so the slave's drive is visible alone.
    task automatic tick();
        @(posedge CLK);
        #1 drv_en = 1'b0;
        #1;
    endtask

    // One master transaction; cut/rst give the cycle index where B_UTIL drops or reset hits.
    // Observation k is taken after the edge that sampled master cycle k.
    task automatic run_txn(input logic [15:0] a, input logic rw, input logic [7:0] d,
                           input int cut, input int rst, input int extra);
        bit         match;
        bit         wp;
        int         last;
        logic [7:0] rd_exp;
        logic       e_ack, e_done, e_bus;
        match  = (a[15:8] == 8'hA5);
        wp     = 1'b0;
`ifdef SLAVE_WRITE_PROTECT_EN
        wp     = S_WP;
`endif
        rd_exp = mem_m[a[7:0]];
        last   = (!match ? 16 : (rw ? 31 : 27)) + extra;
        for (int k = 0; k <= last; k++) begin
            B_UTIL = (k != cut);
            B_RW   = rw;
            RSTN   = (k == rst);
            if (k < 16) begin
                drv_en = 1'b1; drv_val = a[15-k];
            end else if (rw && k >= 20 && k <= 27) begin
                drv_en = 1'b1; drv_val = d[27-k];
            end
            tick();
            if (k == cut || k == rst) begin
                chk($sformatf("abort_ack k=%0d", k), B_ACK, 0);
                chk($sformatf("abort_bsy k=%0d", k), S_BSY, 0);
                chk($sformatf("abort_done k=%0d", k), S_WR_DONE, 0);
                chk($sformatf("abort_bus k=%0d", k), B_BUS, 1);
                if (k == rst) foreach (mem_m[i]) mem_m[i] = 8'h00;
                RSTN = 1'b0;
                break;
            end
            e_ack  = match && ((k >= 15 && k <= 18) || (rw && !wp && k >= 27 && k <= 30));
            e_done = match && rw && !wp && (k == 27);
            e_bus  = (match && !rw && k >= 19 && k <= 26) ? rd_exp[26-k] : 1'b1;
            chk($sformatf("ack a=%h k=%0d", a, k), B_ACK, e_ack);
            chk($sformatf("done a=%h k=%0d", a, k), S_WR_DONE, e_done);
            chk($sformatf("bus a=%h k=%0d", a, k), B_BUS, e_bus);
            chk($sformatf("bsy a=%h k=%0d", a, k), S_BSY, 1);
            if (e_done) mem_m[a[7:0]] = d;
        end
        B_UTIL = 1'b0;
        RSTN   = 1'b0;
        tick();
        chk("end_bsy", S_BSY, 0);
        chk("end_ack", B_ACK, 0);
        chk("end_bus", B_BUS, 1);
    endtask

    initial begin
        logic [15:0] a;
        int          cut;
        drv_en = 1'b0; drv_val = 1'b0;
        B_UTIL = 1'b0; B_RW = 1'b0; RSTN = 1'b1;
`ifdef SLAVE_WRITE_PROTECT_EN
        S_WP = 1'b0;
`endif
        foreach (mem_m[i]) mem_m[i] = 8'h00;
        tick();
        tick();
        chk("rst_ack", B_ACK, 0);
        chk("rst_bsy", S_BSY, 0);
        chk("rst_done", S_WR_DONE, 0);
        chk("rst_bus", B_BUS, 1);
        RSTN = 1'b0;
        tick();
        chk("post_rst_bsy", S_BSY, 0);

        run_txn(16'hA534, 1'b1, 8'h5C, -1, -1, 0);
        run_txn(16'hA534, 1'b0, 8'h00, -1, -1, 1);
        run_txn(16'h1234, 1'b1, 8'hFF, -1, -1, 2);
        run_txn(16'h1234, 1'b0, 8'h00, -1, -1, 0);
        run_txn(16'hA534, 1'b0, 8'h00, -1, -1, 0);
        run_txn(16'hA510, 1'b1, 8'h3B, 24, -1, 0);
        run_txn(16'hA510, 1'b0, 8'h00, -1, -1, 0);
        run_txn(16'hA510, 1'b1, 8'hC6, 27, -1, 0);
        run_txn(16'hA510, 1'b1, 8'h81, 29, -1, 0);
        run_txn(16'hA510, 1'b0, 8'h00, -1, -1, 0);
`ifdef SLAVE_WRITE_PROTECT_EN
        S_WP = 1'b1;
        run_txn(16'hA501, 1'b1, 8'h77, -1, -1, 0);
        S_WP = 1'b0;
        run_txn(16'hA501, 1'b0, 8'h00, -1, -1, 0);
`endif

        for (int t = 0; t < 40; t++) begin
            a[15:8] = ($urandom_range(0, 3) != 0) ? 8'hA5 : 8'($urandom_range(0, 255));
            a[7:0]  = 8'($urandom_range(0, 15));
            cut     = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 32)) : -1;
            run_txn(a, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), cut, -1,
                    int'($urandom_range(0, 3)));
        end

        run_txn(16'hA534, 1'b1, 8'h5C, -1, -1, 0);
        run_txn(16'hA534, 1'b0, 8'h00, -1, 23, 0);
        run_txn(16'hA534, 1'b0, 8'h00, -1, -1, 0);
        for (int t = 0; t < 4; t++)
            run_txn({8'hA5, 8'(t)}, 1'b0, 8'h00, -1, -1, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
